// File: rtl/ahb3_lite_arbiter.sv
// ahb3_lite_arbiter
//   Round-robin scheduler that shares one AHB3-lite slave port among NUM_REQ
//   single-beat command requesters. It is the only AHB master on the port.
//   Each transfer completes before the next one is accepted, so the address
//   and data phases never overlap.
//
// Parameters
//   NUM_REQ         number of requesters (2..8)
//   TIMEOUT_CYCLES  data-phase wait-state limit (only with AHB_ARB_TIMEOUT_EN)
//
// Optional feature macro
//   AHB_ARB_TIMEOUT_EN  abandons a data phase with an error after
//                       TIMEOUT_CYCLES stalled cycles; without it the data
//                       phase waits indefinitely.
//
// Ports
//   clk_i, rst_i                    clock, synchronous active-high reset
//   req_valid_i / req_ready_o       per-requester command handshake (ready one-hot)
//   req_addr_i/write/size/wdata     packed command fields, requester k at slice k
//   rsp_valid_o/rdata_o/err_o       one-hot completion pulse with read data and error
//   haddr_o..hsel_o                 AHB master outputs (SINGLE bursts, IDLE/NONSEQ)
//   hrdata_i, hready_i, hresp_i     AHB slave response
//
// state  | meaning
// S_IDLE | waiting for a request; grants and latches a command
// S_ADDR | address phase: NONSEQ driven, waiting for hready_i
// S_DATA | data phase: write data driven, waiting for hready_i
// S_RESP | one-cycle response pulse to the granted requester
module ahb3_lite_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*32-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]    req_write_i,
    input  logic [NUM_REQ*3-1:0]  req_size_i,
    input  logic [NUM_REQ*32-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [31:0]           haddr_o,
    output logic [2:0]            hburst_o,
    output logic [2:0]            hsize_o,
    output logic [1:0]            htrans_o,
    output logic                  hwrite_o,
    output logic [31:0]           hwdata_o,
    output logic                  hsel_o,
    input  logic [31:0]           hrdata_i,
    input  logic                  hready_i,
    input  logic                  hresp_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [NUM_REQ-1:0] REQ_ONE = NUM_REQ'(1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("ahb3_lite_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_q;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;
    logic             any_valid;
    logic             cmd_write;
    logic [31:0]      cmd_wdata;
    logic             err_q;

    logic [31:0] addr_arr  [NUM_REQ];
    logic [31:0] wdata_arr [NUM_REQ];
    logic [2:0]  size_arr  [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_arr[k]  = req_addr_i[k*32 +: 32];
        assign wdata_arr[k] = req_wdata_i[k*32 +: 32];
        assign size_arr[k]  = req_size_i[k*3 +: 3];
    end

`ifdef AHB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TMO_W-1:0] tmo_cnt;
`endif

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        any_valid = 1'b0;
        grant_idx = rr_ptr;
        cand      = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!any_valid && req_valid_i[cand]) begin
                any_valid = 1'b1;
                grant_idx = cand;
            end
        end
    end

    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [2:0]  sel_size;
    logic        sel_write;
    logic        sel_illegal;

    assign sel_addr  = addr_arr[grant_idx];
    assign sel_wdata = wdata_arr[grant_idx];
    assign sel_size  = size_arr[grant_idx];
    assign sel_write = req_write_i[grant_idx];

    always_comb begin
        sel_illegal = 1'b0;
        if (sel_size > 3'd2)
            sel_illegal = 1'b1;
        else if (sel_size == 3'd1 && sel_addr[0])
            sel_illegal = 1'b1;
        else if (sel_size == 3'd2 && sel_addr[1:0] != 2'b00)
            sel_illegal = 1'b1;
    end

    assign req_ready_o = (state == S_IDLE && any_valid) ? (REQ_ONE << grant_idx) : '0;
    assign hburst_o    = 3'b000;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            grant_q     <= '0;
            cmd_write   <= 1'b0;
            cmd_wdata   <= '0;
            err_q       <= 1'b0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            haddr_o     <= '0;
            hsize_o     <= '0;
            htrans_o    <= HTRANS_IDLE;
            hwrite_o    <= 1'b0;
            hwdata_o    <= '0;
            hsel_o      <= 1'b0;
`ifdef AHB_ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            rsp_valid_o <= '0;
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        grant_q   <= grant_idx;
                        cmd_write <= sel_write;
                        cmd_wdata <= sel_wdata;
                        if (sel_illegal) begin
                            // Rejected locally; the bus is never touched.
                            state       <= S_RESP;
                            rsp_valid_o <= REQ_ONE << grant_idx;
                            rsp_rdata_o <= '0;
                            rsp_err_o   <= 1'b1;
                        end else begin
                            state    <= S_ADDR;
                            haddr_o  <= sel_addr;
                            hwrite_o <= sel_write;
                            hsize_o  <= sel_size;
                            htrans_o <= HTRANS_NONSEQ;
                            hsel_o   <= 1'b1;
                        end
                    end
                end
                S_ADDR: begin
                    if (hready_i) begin
                        state    <= S_DATA;
                        htrans_o <= HTRANS_IDLE;
                        hsel_o   <= 1'b0;
                        hwdata_o <= cmd_wdata;
                        err_q    <= 1'b0;
`ifdef AHB_ARB_TIMEOUT_EN
                        tmo_cnt  <= '0;
`endif
                    end
                end
                S_DATA: begin
                    // Sticky so the first cycle of a two-cycle ERROR is not lost.
                    err_q <= err_q | hresp_i;
                    if (hready_i) begin
                        state       <= S_RESP;
                        rsp_valid_o <= REQ_ONE << grant_q;
                        rsp_rdata_o <= cmd_write ? 32'h0 : hrdata_i;
                        rsp_err_o   <= err_q | hresp_i;
                        hwdata_o    <= '0;
                    end
`ifdef AHB_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state       <= S_RESP;
                        rsp_valid_o <= REQ_ONE << grant_q;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b1;
                        hwdata_o    <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    state  <= S_IDLE;
                    rr_ptr <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
